snn_spike_tally: RTL
====================

SNN_SPIKE_TALLY -- requirements
Module: snn_spike_tally

Interface
REQ-001 SHALL have parameter N, default 8: neurons per frame; index width NI = $clog2(N).
REQ-002 SHALL have parameter DW, default 16: input tdata width.
REQ-003 SHALL have parameter UW, default 8: input tuser width, with UW >= NI.
REQ-004 SHALL have parameter CW, default 8: spike counter width, with CW <= DW.
REQ-005 SHALL have port aclk, input, 1: single clock for all logic.
REQ-006 SHALL have port aresetn, input, 1: asynchronous active-low reset.
REQ-007 SHALL have port s_tvalid, input, 1: upstream beat valid, fed from the core's axis_out.
REQ-008 SHALL have port s_tready, output, 1: ready to accept an upstream beat.
REQ-009 SHALL have port s_tdata, input, DW: neuron state; bit 0 is the spike flag.
REQ-010 SHALL have port s_tuser, input, UW: neuron index in bits [NI-1:0]; upper bits ignored.
REQ-011 SHALL have port s_tlast, input, 1: last beat of a time-step frame.
REQ-012 SHALL have port m_tvalid, output, 1: tally beat valid.
REQ-013 SHALL have port m_tready, input, 1: downstream ready.
REQ-014 SHALL have port m_tdata, output, DW: zero-extended spike count.
REQ-015 SHALL have port m_tuser, output, UW: zero-extended neuron index.
REQ-016 SHALL have port m_tlast, output, 1: asserted on the beat for neuron N-1.
REQ-017 SHALL have port frame_count, output, 16: number of completed dumps, wrapping modulo 2^16.
REQ-018 SHALL have port idx_err, output, 1: sticky flag for an out-of-range index; cleared only by reset.

Function
REQ-019 SHALL implement an FSM with states COLLECT and DUMP.
REQ-020 In COLLECT, s_tready SHALL be 1 and m_tvalid SHALL be 0.
REQ-021 A beat SHALL be accepted only on the cycle where s_tvalid and s_tready are both high.
REQ-022 On each accepted beat with s_tdata[0]=1 and index < N, count[index] SHALL increment by 1, saturating at 2^CW-1.
REQ-023 An accepted beat with index >= N SHALL leave all counts unchanged and SHALL set idx_err on the next edge.
REQ-024 An accepted beat with s_tlast=1 SHALL first be tallied like any other beat, then the FSM SHALL enter DUMP on the same edge, with dump pointer k=0.
REQ-025 In DUMP, s_tready SHALL be 0 and m_tvalid SHALL be 1.
REQ-026 In DUMP, m_tdata SHALL equal count[k], m_tuser SHALL equal k, and m_tlast SHALL equal (k==N-1).
REQ-027 The first output beat SHALL be valid on the cycle after the tlast handshake (latency 1 cycle).
REQ-028 Each output handshake SHALL increment k; while m_tready is low, all m_* outputs SHALL be held stable.
REQ-029 On the m_tlast handshake, all counts SHALL clear to 0, frame_count SHALL increment, and the FSM SHALL return to COLLECT on the same edge.
REQ-030 A frame with fewer or more than N input beats before tlast SHALL still dump exactly N beats.
REQ-031 Repeated indices within a frame SHALL accumulate.

Reset
REQ-032 While aresetn is low: state=COLLECT, all counts=0, k=0, frame_count=0, idx_err=0, m_tvalid=0, m_tdata=0, m_tuser=0, m_tlast=0, s_tready=0.
REQ-033 s_tready SHALL rise on the first aclk edge after aresetn deasserts.
REQ-034 Reset asserted mid-DUMP or mid-COLLECT SHALL abort the frame immediately and discard all partial counts.

Structure
REQ-035 The snn_pkg package SHALL hold the state enum typedef tally_state_t {COLLECT, DUMP}.
REQ-036 snn_pkg SHALL hold the default constants for N and CW.
REQ-037 The count array and saturating increment SHALL live in sub-module spike_count_bank, with ports: inc_en, inc_idx, rd_idx, rd_data, clr_all.
REQ-038 spike_count_bank SHALL provide a combinational read.
REQ-039 spike_count_bank SHALL give clr_all priority over inc_en when both are asserted.

Verification (N=4, CW=4, DW=16, UW=8)
REQ-040 Input beats idx 0..3, data 1,0,1,1, tlast on idx 3; m_tready=1 -> output counts 1,0,1,1 on consecutive cycles starting 1 cycle after tlast; m_tlast on idx 3; frame_count=1.
REQ-041 20 beats to idx 2 with spike=1, then tlast -> count[2]=15 (saturated), all other counts 0.
REQ-042 m_tready toggles 1,0,0,1 during DUMP -> no beat lost or duplicated; m_* outputs stable while stalled; s_tready=0 throughout DUMP.
REQ-043 Beat with tuser=5 and spike=1 -> idx_err=1 persistently; dump counts unaffected.
REQ-044 aresetn pulsed low after 2 output beats -> outputs return to reset values; next frame dumps fresh counts; frame_count restarts from 0.
REQ-045 Two back-to-back frames -> second dump reflects only second-frame spikes; frame_count=2.

Source files
------------

// File: rtl/snn_pkg.sv
// snn_pkg: shared state encoding and default sizes for the spike tally block
package snn_pkg;
    typedef enum logic {COLLECT, DUMP} tally_state_t;
    localparam int N_DEF  = 8;
    localparam int CW_DEF = 8;
endpackage

// File: rtl/spike_count_bank.sv
// spike_count_bank: per-neuron saturating spike counters with combinational read
module spike_count_bank
    import snn_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int CW = CW_DEF,
    parameter int NI = (N > 1) ? $clog2(N) : 1
) (
    input  logic          aclk,
    input  logic          aresetn,
    input  logic          inc_en,
    input  logic [NI-1:0] inc_idx,
    input  logic [NI-1:0] rd_idx,
    output logic [CW-1:0] rd_data,
    input  logic          clr_all
);
    logic [CW-1:0] cnt [N];
    // clear wins over increment; increments stop at all-ones
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) cnt <= '{default: '0};
        else if (clr_all) cnt <= '{default: '0};
        else if (inc_en && cnt[inc_idx] != '1) cnt[inc_idx] <= cnt[inc_idx] + 1'b1;
    end
    assign rd_data = cnt[rd_idx];
endmodule

// File: rtl/snn_spike_tally.sv
// snn_spike_tally: counts spikes per neuron over a frame, then streams the N tallies out
module snn_spike_tally
    import snn_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int DW = 16,
    parameter int UW = 8,
    parameter int CW = CW_DEF
) (
    input  logic          aclk,
    input  logic          aresetn,
    input  logic          s_tvalid,
    output logic          s_tready,
    input  logic [DW-1:0] s_tdata,
    input  logic [UW-1:0] s_tuser,
    input  logic          s_tlast,
    output logic          m_tvalid,
    input  logic          m_tready,
    output logic [DW-1:0] m_tdata,
    output logic [UW-1:0] m_tuser,
    output logic          m_tlast,
    output logic [15:0]   frame_count,
    output logic          idx_err
);
    localparam int NI = (N > 1) ? $clog2(N) : 1;
    // index field is one bit wider for power-of-two N so an index of N or more is observable
    localparam int IW = $clog2(N + 1);
    tally_state_t state;
    logic [NI-1:0] k;
    logic [IW-1:0] idx;
    logic [CW-1:0] rd_data;
    logic acc, in_range, clr, unused_bits;
    assign idx         = s_tuser[IW-1:0];
    assign in_range    = idx < IW'(N);
    assign acc         = s_tvalid && s_tready;
    assign clr         = (state == DUMP) && m_tready && m_tlast;
    assign m_tdata     = m_tvalid ? DW'(rd_data) : '0;
    assign m_tuser     = m_tvalid ? UW'(k) : '0;
    assign unused_bits = ^{s_tdata, s_tuser};

    spike_count_bank #(.N(N), .CW(CW), .NI(NI)) u_bank (
        .aclk    (aclk),
        .aresetn (aresetn),
        .inc_en  (acc && s_tdata[0] && in_range),
        .inc_idx (idx[NI-1:0]),
        .rd_idx  (k),
        .rd_data (rd_data),
        .clr_all (clr)
    );

    // frame control: collect until tlast, then emit one beat per neuron with registered handshakes
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state       <= COLLECT;
            k           <= '0;
            s_tready    <= 1'b0;
            m_tvalid    <= 1'b0;
            m_tlast     <= 1'b0;
            frame_count <= '0;
            idx_err     <= 1'b0;
        end else begin
            if (acc && !in_range) idx_err <= 1'b1;
            if (state == COLLECT) begin
                s_tready <= 1'b1;
                if (acc && s_tlast) begin
                    state    <= DUMP;
                    k        <= '0;
                    s_tready <= 1'b0;
                    m_tvalid <= 1'b1;
                    m_tlast  <= (N == 1);
                end
            end else if (m_tready) begin
                if (m_tlast) begin
                    state       <= COLLECT;
                    k           <= '0;
                    s_tready    <= 1'b1;
                    m_tvalid    <= 1'b0;
                    m_tlast     <= 1'b0;
                    frame_count <= frame_count + 1'b1;
                end else begin
                    k       <= k + 1'b1;
                    m_tlast <= (k + 1'b1 == NI'(N - 1));
                end
            end
        end
    end
endmodule
